// File: rtl/axis_arb_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and helpers for the packet-level AXI-Stream round-robin arbiter.
//   arb_state_t : arbitration FSM state (IDLE waits for requests, BUSY owns a
//                 packet until its tlast beat is accepted)
//   rr_pick     : round-robin search over a request vector starting at ptr
// -----------------------------------------------------------------------------
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Upper bound on the number of requesters rr_pick can scan.
    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_REQ_W = 5;

    // Returns the first index i with req[i] set, searching upward from ptr and
    // wrapping num-1 -> 0. Only bits [num-1:0] of req are considered. When no
    // bit is set the result is ptr; callers only use it when a request exists.
    function automatic int unsigned rr_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        ptr,
        input int unsigned        num
    );
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= num) begin
                idx = idx - num;
            end
            if ((k < num) && !found && req[idx[MAX_REQ_W-1:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Single-entry registered output stage with valid/ready load-drain behaviour.
// The upstream side is only allowed to assert load when the stage can take a
// beat (empty, or draining in the same cycle); the caller enforces that.
//   clock     : rising-edge clock
//   resetn    : synchronous active-low reset (clears data and valid)
//   load      : capture load_data this cycle
//   load_data : beat to capture (W bits)
//   out_ready : downstream ready
//   out_data  : registered beat, held stable while stalled
//   out_valid : registered beat is valid
// -----------------------------------------------------------------------------
module axis_out_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid
);

    logic [W-1:0] data_p1;
    logic         vld_p1;

    // ---- stage p1: output register ----
    always_ff @(posedge clock) begin
        if (!resetn) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (load) begin
            // A load wins over a drain: a simultaneous drain+load keeps valid high.
            data_p1 <= load_data;
            vld_p1  <= 1'b1;
        end else if (vld_p1 && out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;

endmodule

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-level round-robin arbiter sharing one AXI-Stream master among NUM
// slaves. A grant is held until the granted requester's tlast beat is accepted,
// so packets never interleave. Output is registered (axis_out_reg).
//   clock, resetn : rising-edge clock, synchronous active-low reset
//   s_tdata       : NUM*dw slave data, requester i at [i*dw +: dw]
//   s_tvalid      : per-requester valid
//   s_tready      : per-requester ready (only the granted bit can be high)
//   s_tlast       : per-requester end-of-packet
//   m_tdata       : shared output data
//   m_tvalid      : shared output valid
//   m_tready      : downstream ready
//   m_tlast       : shared output end-of-packet
//   m_tid         : index of the requester that sourced the output beat
// -----------------------------------------------------------------------------
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int dw  = 8,
    parameter  int NUM = 4,
    localparam int IDW = $clog2(NUM)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [NUM*dw-1:0] s_tdata,
    input  logic [NUM-1:0]    s_tvalid,
    output logic [NUM-1:0]    s_tready,
    input  logic [NUM-1:0]    s_tlast,
    output logic [dw-1:0]     m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [IDW-1:0]    m_tid
);

    arb_state_t         state, state_nxt;
    logic [IDW-1:0]     gnt, gnt_nxt;
    logic [IDW-1:0]     rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]     pick;
    logic [MAX_REQ-1:0] req_ext;
    logic [dw-1:0]      s_data_arr [NUM];
    logic               gnt_ready;
    logic               accept;
    logic               out_vld;

    for (genvar i = 0; i < NUM; i++) begin : g_unpack
        assign s_data_arr[i] = s_tdata[i*dw +: dw];
    end

    always_comb begin
        req_ext           = '0;
        req_ext[NUM-1:0]  = s_tvalid;
    end

    assign pick = IDW'(rr_pick(req_ext, 32'(rr_ptr), NUM));

    // Ready depends only on registered state, never on s_tvalid.
    assign gnt_ready = !out_vld || m_tready;
    assign accept    = (state == BUSY) && s_tvalid[gnt] && gnt_ready;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        s_tready   = '0;
        case (state)
            IDLE: begin
                if (|s_tvalid) begin
                    gnt_nxt   = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                s_tready[gnt] = gnt_ready;
                // Packet ends on an accepted tlast beat; the pointer moves past
                // the finished requester so the others get a turn first.
                if (accept && s_tlast[gnt]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (gnt == IDW'(NUM - 1)) ? '0 : gnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    axis_out_reg #(
        .W (dw + 1 + IDW)
    ) u_out_reg (
        .clock     (clock),
        .resetn    (resetn),
        .load      (accept),
        .load_data ({s_data_arr[gnt], s_tlast[gnt], gnt}),
        .out_ready (m_tready),
        .out_data  ({m_tdata, m_tlast, m_tid}),
        .out_valid (out_vld)
    );

    assign m_tvalid = out_vld;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;

    localparam int DW  = 8;
    localparam int NUM = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           last;
    } beat_t;

    logic              clock = 1'b0;
    logic              resetn;
    logic [NUM*DW-1:0] s_tdata;
    logic [NUM-1:0]    s_tvalid;
    logic [NUM-1:0]    s_tready;
    logic [NUM-1:0]    s_tlast;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [IDW-1:0]    m_tid;

    int      n_cmp;
    int      n_err;
    beat_t   exp_q[$];
    logic [DW:0] src_q[NUM][$];
    int      acc_cnt[NUM];
    int      gap_after[NUM];
    int      gap_left[NUM];
    bit      rand_mode;

    always #5 clock = ~clock;

    axis_rr_arbiter #(.dw(DW), .NUM(NUM)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_m_tdata"},  32'(m_tdata),  32'd0);
        check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_m_tlast"},  32'(m_tlast),  32'd0);
        check({tag, "_m_tid"},    32'(m_tid),    32'd0);
        check({tag, "_s_tready"}, 32'(s_tready), 32'd0);
    endtask

    task automatic push_pkt(input int id, input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            src_q[id].push_back({(k == n - 1), base + DW'(k)});
        end
    endtask

    task automatic expect_pkt(input int id, input logic [DW-1:0] base, input int n, input bit ends);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.id   = IDW'(id);
            b.data = base + DW'(k);
            b.last = ends && (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    function automatic bit sources_empty();
        bit e = 1'b1;
        for (int i = 0; i < NUM; i++) begin
            if (src_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    // Presents queued beats; handshakes are sampled on the falling edge and
    // retired just after the following rising edge.
    task automatic driver_loop();
        logic [NUM-1:0]    acc;
        logic [NUM-1:0]    tv;
        logic [NUM-1:0]    tl;
        logic [NUM*DW-1:0] td;
        logic [DW:0]       b;
        forever begin
            @(negedge clock);
            acc = s_tvalid & s_tready;
            @(posedge clock);
            #1;
            for (int i = 0; i < NUM; i++) begin
                if (!resetn) begin
                    src_q[i].delete();
                    acc_cnt[i]  = 0;
                    gap_left[i] = 0;
                end else if (acc[i] && src_q[i].size() > 0) begin
                    b = src_q[i].pop_front();
                    acc_cnt[i]++;
                end
            end
            if (rand_mode) begin
                s_tvalid = NUM'($urandom);
                s_tlast  = NUM'($urandom);
                s_tdata  = $urandom;
            end else begin
                tv = '0;
                tl = '0;
                td = '0;
                for (int i = 0; i < NUM; i++) begin
                    if (src_q[i].size() > 0) begin
                        if (acc_cnt[i] == gap_after[i] && gap_left[i] > 0) begin
                            gap_left[i]--;
                        end else begin
                            b              = src_q[i][0];
                            tv[i]          = 1'b1;
                            tl[i]          = b[DW];
                            td[i*DW +: DW] = b[DW-1:0];
                        end
                    end
                end
                s_tvalid = tv;
                s_tlast  = tl;
                s_tdata  = td;
            end
        end
    endtask

    task automatic monitor_loop();
        beat_t cur;
        beat_t held;
        beat_t e;
        bit    stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clock);
            cur.id   = m_tid;
            cur.data = m_tdata;
            cur.last = m_tlast;
            if (m_tvalid) begin
                if (stalled) check("hold_stable", 32'(cur), 32'(held));
                if (!m_tready) begin
                    held    = cur;
                    stalled = 1'b1;
                    check("stall_s_tready", 32'(s_tready), 32'd0);
                end else begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got id=%0d data=0x%0h last=%0d, expected no beat",
                                 cur.id, cur.data, cur.last);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat(id,data,last)", 32'(cur), 32'(e));
                    end
                end
            end else begin
                stalled = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget, input bit bp);
        logic [3:0] pat;
        bit         done;
        int         cyc;
        pat  = 4'b1001;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < budget) begin
            @(posedge clock);
            #1;
            m_tready = bp ? pat[cyc % 4] : 1'b1;
            @(negedge clock);
            cyc++;
            if (exp_q.size() == 0 && sources_empty()) done = 1'b1;
        end
        m_tready = 1'b1;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_complete: %0d beats still expected, required 0", name, exp_q.size());
            exp_q.delete();
            for (int i = 0; i < NUM; i++) src_q[i].delete();
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        bit seen;
        n_cmp     = 0;
        n_err     = 0;
        resetn    = 1'b0;
        m_tready  = 1'b1;
        rand_mode = 1'b1;
        s_tvalid  = '0;
        s_tlast   = '0;
        s_tdata   = '0;
        for (int i = 0; i < NUM; i++) begin
            acc_cnt[i]   = 0;
            gap_after[i] = -1;
            gap_left[i]  = 0;
        end
        fork
            driver_loop();
            monitor_loop();
        join_none

        // Reset with random inputs, then lowest valid index wins from rr_ptr=0.
        repeat (3) begin
            @(negedge clock);
            check_zero_outputs("reset");
            m_tready = 1'($urandom);
        end
        rand_mode = 1'b0;
        m_tready  = 1'b1;
        @(posedge clock);
        #2;
        resetn = 1'b1;
        push_pkt(2, 8'h20, 1);
        push_pkt(3, 8'h30, 1);
        expect_pkt(2, 8'h20, 1, 1'b1);
        expect_pkt(3, 8'h30, 1, 1'b1);
        wait_done("first_grant", 40, 1'b0);

        // Round robin: rr_ptr=0, grants 0,1,2,3 then 0 again.
        push_pkt(0, 8'h00, 2);
        push_pkt(0, 8'h00, 2);
        push_pkt(1, 8'h10, 2);
        push_pkt(2, 8'h20, 2);
        push_pkt(3, 8'h30, 2);
        expect_pkt(0, 8'h00, 2, 1'b1);
        expect_pkt(1, 8'h10, 2, 1'b1);
        expect_pkt(2, 8'h20, 2, 1'b1);
        expect_pkt(3, 8'h30, 2, 1'b1);
        expect_pkt(0, 8'h00, 2, 1'b1);
        wait_done("round_robin", 80, 1'b0);

        // Packet lock: rr_ptr=1, requester 1's 4 beats before requester 0.
        push_pkt(1, 8'h1a, 4);
        push_pkt(0, 8'h0c, 2);
        expect_pkt(1, 8'h1a, 4, 1'b1);
        expect_pkt(0, 8'h0c, 2, 1'b1);
        wait_done("packet_lock", 60, 1'b0);

        // Backpressure: rr_ptr=1, m_tready pattern 1,0,0,1.
        push_pkt(1, 8'h14, 3);
        expect_pkt(1, 8'h14, 3, 1'b1);
        wait_done("backpressure", 60, 1'b1);

        // Upstream gap: rr_ptr=2, requester 2 drops valid 3 cycles after beat 2.
        for (int i = 0; i < NUM; i++) acc_cnt[i] = 0;
        gap_after[2] = 2;
        gap_left[2]  = 3;
        push_pkt(2, 8'h24, 4);
        push_pkt(0, 8'h0a, 1);
        expect_pkt(2, 8'h24, 4, 1'b1);
        expect_pkt(0, 8'h0a, 1, 1'b1);
        wait_done("upstream_gap", 60, 1'b0);
        gap_after[2] = -1;

        // Reset mid-packet: rr_ptr=1, requester 2 sends 5 beats, reset after beat 2.
        for (int i = 0; i < NUM; i++) acc_cnt[i] = 0;
        push_pkt(2, 8'h50, 5);
        expect_pkt(2, 8'h50, 2, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clock);
            if (acc_cnt[2] == 2) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL mid_rst_beat2_accepted: got %0d beats, expected 2", acc_cnt[2]);
        end
        #1;
        resetn = 1'b0;
        @(negedge clock);
        check_zero_outputs("mid_rst");
        #1;
        resetn = 1'b1;
        // rr_ptr back at 0: requester 0 ahead of requester 3.
        push_pkt(0, 8'h60, 1);
        push_pkt(3, 8'h70, 2);
        expect_pkt(0, 8'h60, 1, 1'b1);
        expect_pkt(3, 8'h70, 2, 1'b1);
        wait_done("after_reset", 60, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream master port among NUM AXI-Stream slave ports. Once a requester is granted, the grant is held until that requester's beat with `s_tlast` is accepted, so packets never interleave. Output is registered and sits in front of the existing single-register AXI-Stream stage on the shared datapath.

## Interface
- `dw`, 8: data width per stream.
- `NUM`, 4: number of requesters (≥2).
- `IDW`, `$clog2(NUM)`: grant-index width (derived, not overridden).

- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `s_tdata`  in  NUM*dw  slave data; requester i at bits [i*dw +: dw].
- `s_tvalid`  in  NUM  per-requester valid.
- `s_tready`  out  NUM  per-requester ready.
- `s_tlast`  in  NUM  per-requester end-of-packet.
- `m_tdata`  out  dw  shared output data.
- `m_tvalid`  out  1  shared output valid.
- `m_tready`  in  1  downstream ready.
- `m_tlast`  out  1  shared output end-of-packet.
- `m_tid`  out  IDW  index of the requester that sourced the current output beat.

## Operation
- State machine: `IDLE`, `BUSY`.
- `IDLE`: if any `s_tvalid` is high, select the first i with `s_tvalid[i]` searching upward from `rr_ptr`, wrapping NUM-1 → 0. Register `gnt <= i` and go to `BUSY`. With no request, stay in `IDLE`. `s_tready` is all-zero in `IDLE`.
- `BUSY`: `s_tready[gnt] = !m_tvalid || m_tready`. All other `s_tready` bits are 0. This is combinational from registers only and never depends on `s_tvalid`.
- Beat accepted when `s_tvalid[gnt] && s_tready[gnt]`:
  - the output register loads `s_tdata[gnt]`, `s_tlast[gnt]` and `gnt`;
  - `m_tvalid <= 1`.
- Output register drains when `m_tvalid && m_tready`. If no new beat is loaded in that cycle, `m_tvalid <= 0`. Load and drain may occur in the same cycle; output then stays valid with the new beat.
- An accepted beat with `s_tlast=1` ends the packet:
  - next state `IDLE`;
  - `rr_ptr <= (gnt==NUM-1) ? 0 : gnt+1`.
- The grant is never revoked mid-packet. If `s_tvalid[gnt]` drops inside a packet, the arbiter waits in `BUSY`.
- Output holds stable (data, last, id) while `m_tvalid && !m_tready`.

## Timing
- Reset values: `m_tdata=0`, `m_tvalid=0`, `m_tlast=0`, `m_tid=0`, `s_tready=0`; internal `state=IDLE`, `gnt=0`, `rr_ptr=0`.
- Reset asserted mid-packet: the partial packet is discarded. All of the above values are restored on the next edge, with no flush beat.
- Latency with `m_tready=1`:
  - `s_tvalid` first seen at edge N: grant registered at N.
  - First beat accepted at N+1.
  - `m_tvalid` high after N+1.
- Throughput inside a packet: 1 beat/cycle while `m_tready=1`.
- Between packets: exactly one arbitration cycle in `IDLE`, so at least one bubble.
- Single-beat packet (`s_tlast` on first beat): `BUSY` for one cycle, then `IDLE`.
- All requesters valid continuously: grants rotate 0,1,2,3,0…
- A requester that is the only one valid is re-granted every packet.

## Structure
- Shared package `axis_arb_pkg`:
  - state enum {`IDLE`, `BUSY`};
  - helper function `rr_pick(req, ptr)` returning the next index.
- One sub-module, `axis_out_reg`: the dw+1+IDW-wide output register with valid/ready load-drain logic.
- Arbitration FSM and `rr_ptr` live in the top.

## Test plan
- Reset: hold `resetn=0` 3 cycles with random inputs → all outputs 0; first grant after release goes to the lowest valid index ≥0.
- Round-robin: all 4 requesters send 2-beat packets (data `0xi0`, `0xi1`) with `m_tready=1` → output sequence id 0,1,2,3,0 with one bubble between packets, data in order.
- Packet lock: requester 1 sends 4 beats while requester 0 holds valid → no beat from 0 appears until after 1's `tlast`; next grant is 2 if valid, else 0.
- Backpressure: `m_tready` toggles 1,0,0,1 during a 3-beat packet → `m_tdata` stable while stalled, no beat lost or duplicated, `s_tready[gnt]` low on stall cycles with the register full.
- Upstream gap: requester 2 drops valid for 3 cycles mid-packet → arbiter stays `BUSY`, no other id appears, packet completes intact.
- Reset mid-packet: assert `resetn=0` after beat 2 of 5 → outputs return to 0, `rr_ptr=0`, and the next packet from requester 3 is granted normally.
